// File: rtl/decode_bypass_ctrl_if.sv
// Decode-stage bypass bus: decode instruction fields, register file read data,
// per-stage bypass values, and the forwarded operands and stall coming back.
interface decode_bypass_ctrl_if #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int BP_DEPTH  = 3
);
    localparam int SRC_W = $clog2(BP_DEPTH + 1);

    logic                         stall_in;
    logic                         flush;
    logic                         dec_valid;
    logic [RF_ADDR_W-1:0]         dec_rd;
    logic                         dec_rd_we;
    logic                         dec_is_load;
    logic [RF_ADDR_W-1:0]         dec_ra;
    logic [RF_ADDR_W-1:0]         dec_rb;
    logic                         dec_ra_used;
    logic                         dec_rb_used;
    logic [DATA_W-1:0]            rf_ra_data;
    logic [DATA_W-1:0]            rf_rb_data;
    logic [BP_DEPTH*DATA_W-1:0]   stage_data;
    logic [DATA_W-1:0]            op_a;
    logic [DATA_W-1:0]            op_b;
    logic [SRC_W-1:0]             op_a_src;
    logic [SRC_W-1:0]             op_b_src;
    logic                         stall_decode;
    logic                         issue_valid;
    logic [15:0]                  hazard_cnt;

    modport master (
        output stall_in, flush, dec_valid, dec_rd, dec_rd_we, dec_is_load,
               dec_ra, dec_rb, dec_ra_used, dec_rb_used,
               rf_ra_data, rf_rb_data, stage_data,
        input  op_a, op_b, op_a_src, op_b_src, stall_decode, issue_valid, hazard_cnt
    );

    modport slave (
        input  stall_in, flush, dec_valid, dec_rd, dec_rd_we, dec_is_load,
               dec_ra, dec_rb, dec_ra_used, dec_rb_used,
               rf_ra_data, rf_rb_data, stage_data,
        output op_a, op_b, op_a_src, op_b_src, stall_decode, issue_valid, hazard_cnt
    );
endinterface

// File: rtl/decode_bypass_ctrl.sv
// Operand forwarding and load-use hazard control for decode. Tracks the
// destination of each in-flight downstream stage and picks the youngest match.
module decode_bypass_ctrl #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int BP_DEPTH  = 3,
    parameter int LOAD_LAT  = 1
) (
    input logic              clock,
    input logic              reset_c,
    decode_bypass_ctrl_if.slave bp
);
    localparam int SRC_W = $clog2(BP_DEPTH + 1);

    typedef struct packed {
        logic              haz;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] op;
    } fwd_t;

    logic [BP_DEPTH-1:0]                r_vld;
    logic [BP_DEPTH-1:0]                r_we;
    logic [BP_DEPTH-1:0]                r_ld;
    logic [BP_DEPTH-1:0][RF_ADDR_W-1:0] r_rd;
    logic [15:0]                        r_hcnt;

    logic [BP_DEPTH*DATA_W-1:0] w_stage;
    fwd_t                       w_fa;
    fwd_t                       w_fb;
    logic                       w_stall;
    logic                       w_issue;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    function automatic fwd_t resolve(
        input logic [RF_ADDR_W-1:0]              s,
        input logic                              used,
        input logic [DATA_W-1:0]                 rf,
        input logic [BP_DEPTH-1:0]               vld,
        input logic [BP_DEPTH-1:0]               we,
        input logic [BP_DEPTH-1:0]               ld,
        input logic [BP_DEPTH-1:0][RF_ADDR_W-1:0] rd,
        input logic [BP_DEPTH*DATA_W-1:0]        sd
    );
        fwd_t f;
        f.haz = 1'b0;
        f.src = '0;
        f.op  = rf;
        for (int k = BP_DEPTH - 1; k >= 0; k--) begin
            if (vld[k] && we[k] && (rd[k] == s) && (s != '0) && used) begin
                f.haz = ld[k] && (k < LOAD_LAT);
                f.src = SRC_W'(k + 1);
                f.op  = sd[k*DATA_W +: DATA_W];
            end
        end
        return f;
    endfunction

    assign w_stage = bp.stage_data;

    always_comb begin
        w_fa = resolve(bp.dec_ra, bp.dec_ra_used, bp.rf_ra_data, r_vld, r_we, r_ld, r_rd, w_stage);
        w_fb = resolve(bp.dec_rb, bp.dec_rb_used, bp.rf_rb_data, r_vld, r_we, r_ld, r_rd, w_stage);
    end

    assign w_stall = bp.dec_valid && !bp.flush && (w_fa.haz || w_fb.haz);
    assign w_issue = bp.dec_valid && !bp.flush && !w_stall && !bp.stall_in;

    assign bp.op_a         = w_fa.op;
    assign bp.op_b         = w_fb.op;
    assign bp.op_a_src     = w_fa.src;
    assign bp.op_b_src     = w_fb.src;
    assign bp.stall_decode = w_stall;
    assign bp.issue_valid  = w_issue;
    assign bp.hazard_cnt   = r_hcnt;

    // A stalled or flushed decode slot enters the pipe as a bubble via w_issue.
    always_ff @(posedge clock or negedge reset_c) begin
        if (!reset_c) begin
            r_vld  <= '0;
            r_we   <= '0;
            r_ld   <= '0;
            r_rd   <= '0;
            r_hcnt <= '0;
        end else if (!bp.stall_in) begin
            for (int k = BP_DEPTH - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_we[k]  <= r_we[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= w_issue;
            r_we[0]  <= bp.dec_rd_we;
            r_ld[0]  <= bp.dec_is_load;
            r_rd[0]  <= bp.dec_rd;
            if (w_stall && (r_hcnt != 16'hFFFF))
                r_hcnt <= r_hcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_decode_bypass_ctrl.sv
// Directed bench for decode_bypass_ctrl: forwarding distance, priority,
// load-use stall, r0/unused operands, stall_in freeze, flush and reset.
module tb_decode_bypass_ctrl;
    logic clock;
    logic reset_c;
    int   n_total;
    int   n_pass;

    decode_bypass_ctrl_if #(.DATA_W(32), .RF_ADDR_W(5), .BP_DEPTH(3)) bus ();

    decode_bypass_ctrl #(.DATA_W(32), .RF_ADDR_W(5), .BP_DEPTH(3), .LOAD_LAT(1)) dut (
        .clock   (clock),
        .reset_c (reset_c),
        .bp      (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic dec(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] ra, input logic rau, input logic [4:0] rb, input logic rbu);
        bus.dec_valid   = v;
        bus.dec_rd      = rd;
        bus.dec_rd_we   = we;
        bus.dec_is_load = ld;
        bus.dec_ra      = ra;
        bus.dec_ra_used = rau;
        bus.dec_rb      = rb;
        bus.dec_rb_used = rbu;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset_c = 1'b0;
        bus.stall_in   = 1'b0;
        bus.flush      = 1'b0;
        bus.rf_ra_data = 32'h11;
        bus.rf_rb_data = 32'h22;
        bus.stage_data = {32'hCC, 32'hBB, 32'hAA};
        dec(1, 5'd0, 0, 0, 5'd3, 1, 5'd0, 0);
        #3;
        chk("reset_op_a", bus.op_a, 32'h11);
        chk("reset_src_a", 32'(bus.op_a_src), 32'd0);
        chk("reset_stall", 32'(bus.stall_decode), 32'd0);
        chk("reset_hcnt", 32'(bus.hazard_cnt), 32'd0);
        #4 reset_c = 1'b1;

        // ALU forwarding at distance 1 and 2
        cyc();
        dec(1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
        #3 chk("alu_issue", 32'(bus.issue_valid), 32'd1);
        cyc();
        dec(1, 5'd0, 0, 0, 5'd5, 1, 5'd0, 0);
        #3 chk("dist1_op_a", bus.op_a, 32'hAA);
        chk("dist1_src_a", 32'(bus.op_a_src), 32'd1);
        cyc();
        #3 chk("dist2_op_a", bus.op_a, 32'hBB);
        chk("dist2_src_a", 32'(bus.op_a_src), 32'd2);

        // Youngest of two producers wins
        cyc();
        dec(1, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
        cyc();
        cyc();
        dec(1, 5'd0, 0, 0, 5'd0, 0, 5'd7, 1);
        #3 chk("prio_src_b", 32'(bus.op_b_src), 32'd1);
        chk("prio_op_b", bus.op_b, 32'hAA);

        // Load-use: one stall cycle, bubble, then forward from stage 1
        cyc();
        dec(1, 5'd4, 1, 1, 5'd0, 0, 5'd0, 0);
        cyc();
        dec(1, 5'd8, 1, 0, 5'd4, 1, 5'd8, 1);
        #3 chk("lu_stall", 32'(bus.stall_decode), 32'd1);
        chk("lu_issue", 32'(bus.issue_valid), 32'd0);
        cyc();
        #3 chk("lu_hcnt", 32'(bus.hazard_cnt), 32'd1);
        chk("lu_stall_clr", 32'(bus.stall_decode), 32'd0);
        chk("lu_op_a", bus.op_a, 32'hBB);
        chk("lu_src_a", 32'(bus.op_a_src), 32'd2);
        chk("lu_issue2", 32'(bus.issue_valid), 32'd1);
        chk("lu_bubble_src_b", 32'(bus.op_b_src), 32'd0);
        chk("lu_bubble_op_b", bus.op_b, 32'h22);

        // r0 is never forwarded; an unused operand never stalls
        cyc();
        dec(1, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0);
        cyc();
        dec(1, 5'd6, 1, 1, 5'd0, 1, 5'd0, 0);
        #3 chk("r0_src_a", 32'(bus.op_a_src), 32'd0);
        chk("r0_op_a", bus.op_a, 32'h11);
        cyc();
        dec(1, 5'd0, 0, 0, 5'd0, 0, 5'd6, 0);
        #3 chk("unused_stall", 32'(bus.stall_decode), 32'd0);
        chk("unused_src_b", 32'(bus.op_b_src), 32'd0);

        // stall_in freezes tracking and the hazard counter
        cyc();
        dec(1, 5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
        cyc();
        dec(1, 5'd0, 0, 0, 5'd9, 1, 5'd0, 0);
        bus.stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3 chk("frz_stall", 32'(bus.stall_decode), 32'd1);
            chk("frz_hcnt", 32'(bus.hazard_cnt), 32'd1);
            chk("frz_issue", 32'(bus.issue_valid), 32'd0);
            cyc();
        end
        bus.stall_in = 1'b0;
        #3 chk("unfrz_stall", 32'(bus.stall_decode), 32'd1);
        cyc();
        #3 chk("unfrz_hcnt", 32'(bus.hazard_cnt), 32'd2);
        chk("unfrz_src_a", 32'(bus.op_a_src), 32'd2);

        // Flush kills the decode slot and inserts a bubble
        cyc();
        dec(1, 5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
        bus.flush = 1'b1;
        #3 chk("flush_issue", 32'(bus.issue_valid), 32'd0);
        cyc();
        bus.flush = 1'b0;
        dec(1, 5'd0, 0, 0, 5'd10, 1, 5'd0, 0);
        #3 chk("flush_src_a", 32'(bus.op_a_src), 32'd0);
        chk("flush_op_a", bus.op_a, 32'h11);

        // Reset mid-stream clears tracking and counter
        cyc();
        dec(1, 5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
        cyc();
        dec(1, 5'd0, 0, 0, 5'd11, 1, 5'd0, 0);
        #1 chk("pre_rst_src_a", 32'(bus.op_a_src), 32'd1);
        #1 reset_c = 1'b0;
        #1 chk("rst_src_a", 32'(bus.op_a_src), 32'd0);
        chk("rst_op_a", bus.op_a, 32'h11);
        chk("rst_hcnt", 32'(bus.hazard_cnt), 32'd0);
        #1 reset_c = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
